// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the writeback-side register file and load scoreboard.
package reg_file_wb_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/Mux_2_1.sv
// Generic 2:1 multiplexer: y = sel ? d1 : d0.
module Mux_2_1 #(
  parameter int unsigned W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/load_scoreboard.sv
// Pending-load busy flags with set-over-clear priority and the ID-stage stall decision.
module load_scoreboard
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned NR = NUM_REGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_dst,
  input  logic          load_issue,
  input  logic [AW-1:0] load_dst,
  input  logic [AW-1:0] rd1,
  input  logic [AW-1:0] rd2,
  output logic          stall,
  output logic [NR-1:0] busy_mask
);
  logic [NR-1:0] busy;
  logic [NR-1:0] busy_next;
  logic          stall1;
  logic          stall2;

  // Clear is applied first so a same-cycle issue to the same register re-sets it.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[wr_dst] = 1'b0;
    if (load_issue && load_dst != AW'(REG_ZERO)) busy_next[load_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // A WB write to the same register this cycle is forwarded, so it does not stall.
  always_comb begin
    stall1 = (rd1 != AW'(REG_ZERO)) && busy[rd1] && !(wr_en && wr_dst == rd1);
    stall2 = (rd2 != AW'(REG_ZERO)) && busy[rd2] && !(wr_en && wr_dst == rd2);
    stall  = !rst && (stall1 || stall2);
  end

  assign busy_mask = busy;
endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file written from WB, read from ID with WB bypass, plus load scoreboard.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned NR = NUM_REGS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          MEMWBRegWriteOut,
  input  logic [AW-1:0] MEMWBDstOut,
  input  logic [DW-1:0] MEMWBWriteData,
  input  logic [AW-1:0] ReadReg1,
  input  logic [AW-1:0] ReadReg2,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
  input  logic          LoadIssue,
  input  logic [AW-1:0] LoadDst,
  output logic          LoadStall,
  output logic [NR-1:0] BusyMask
);
  logic [DW-1:0] regs [NR];
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] byp1;
  logic [DW-1:0] byp2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NR; i++) regs[i] <= '0;
    end else if (MEMWBRegWriteOut && MEMWBDstOut != AW'(REG_ZERO)) begin
      regs[MEMWBDstOut] <= MEMWBWriteData;
    end
  end

  assign hit1 = MEMWBRegWriteOut && (MEMWBDstOut == ReadReg1);
  assign hit2 = MEMWBRegWriteOut && (MEMWBDstOut == ReadReg2);

  Mux_2_1 #(.W(DW)) u_byp1 (.sel(hit1), .d0(regs[ReadReg1]), .d1(MEMWBWriteData), .y(byp1));
  Mux_2_1 #(.W(DW)) u_byp2 (.sel(hit2), .d0(regs[ReadReg2]), .d1(MEMWBWriteData), .y(byp2));

  // Reset forces zero even though the bypass path would otherwise forward live WB data.
  always_comb begin
    ReadData1 = byp1;
    ReadData2 = byp2;
    if (reset || ReadReg1 == AW'(REG_ZERO)) ReadData1 = '0;
    if (reset || ReadReg2 == AW'(REG_ZERO)) ReadData2 = '0;
  end

  load_scoreboard #(.AW(AW), .NR(NR)) u_sb (
    .clk        (clock),
    .rst        (reset),
    .wr_en      (MEMWBRegWriteOut),
    .wr_dst     (MEMWBDstOut),
    .load_issue (LoadIssue),
    .load_dst   (LoadDst),
    .rd1        (ReadReg1),
    .rd2        (ReadReg2),
    .stall      (LoadStall),
    .busy_mask  (BusyMask)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;
  logic        clock;
  logic        reset;
  logic        MEMWBRegWriteOut;
  logic [4:0]  MEMWBDstOut;
  logic [31:0] MEMWBWriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        LoadIssue;
  logic [4:0]  LoadDst;
  logic        LoadStall;
  logic [31:0] BusyMask;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_file_wb #(.DW(32), .AW(5), .NR(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .MEMWBRegWriteOut (MEMWBRegWriteOut),
    .MEMWBDstOut      (MEMWBDstOut),
    .MEMWBWriteData   (MEMWBWriteData),
    .ReadReg1         (ReadReg1),
    .ReadReg2         (ReadReg2),
    .ReadData1        (ReadData1),
    .ReadData2        (ReadData2),
    .LoadIssue        (LoadIssue),
    .LoadDst          (LoadDst),
    .LoadStall        (LoadStall),
    .BusyMask         (BusyMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic en, input logic [4:0] dst, input logic [31:0] data);
    MEMWBRegWriteOut = en;
    MEMWBDstOut      = dst;
    MEMWBWriteData   = data;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    ReadReg1 = 5'd5; ReadReg2 = 5'd31;
    LoadIssue = 1'b0; LoadDst = 5'd0;
    #2;
    chk("rst_rd1", ReadData1, 32'h0);
    chk("rst_rd2", ReadData2, 32'h0);
    chk("rst_stall", {31'b0, LoadStall}, 32'h0);
    chk("rst_busy", BusyMask, 32'h0);
    // A WB write presented during reset must not be forwarded or committed.
    wb(1'b1, 5'd5, 32'hFFFF_FFFF);
    #1;
    chk("rst_bypass_blocked", ReadData1, 32'h0);
    @(posedge clock);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_write_dropped", ReadData1, 32'h0);

    // Write r7, read next cycle.
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    ReadReg1 = 5'd7;
    #1;
    chk("r7_read", ReadData1, 32'hDEAD_BEEF);

    // Write to r0 is dropped, also in the write cycle itself.
    wb(1'b1, 5'd0, 32'h1234);
    ReadReg1 = 5'd0;
    #1;
    chk("r0_write_cycle", ReadData1, 32'h0);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_after", ReadData1, 32'h0);

    // Bypass: r9 holds 0x11, then WB writes 0xA5A5A5A5 while both ports read r9.
    wb(1'b1, 5'd9, 32'h11);
    next_cycle();
    ReadReg1 = 5'd9; ReadReg2 = 5'd9;
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r9_old", ReadData1, 32'h11);
    wb(1'b1, 5'd9, 32'hA5A5_A5A5);
    #1;
    chk("byp_rd1", ReadData1, 32'hA5A5_A5A5);
    chk("byp_rd2", ReadData2, 32'hA5A5_A5A5);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("byp_after_rd1", ReadData1, 32'hA5A5_A5A5);
    chk("byp_after_rd2", ReadData2, 32'hA5A5_A5A5);

    // Load stall lifecycle on r4.
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    LoadIssue = 1'b1; LoadDst = 5'd4;
    next_cycle();
    LoadIssue = 1'b0; LoadDst = 5'd0;
    ReadReg2 = 5'd4;
    #1;
    chk("ld_stall", {31'b0, LoadStall}, 32'h1);
    chk("ld_busy", BusyMask, 32'h0000_0010);
    next_cycle();
    #1;
    chk("ld_stall_hold", {31'b0, LoadStall}, 32'h1);
    next_cycle();
    wb(1'b1, 5'd4, 32'h55);
    #1;
    chk("ld_wb_nostall", {31'b0, LoadStall}, 32'h0);
    chk("ld_wb_rd2", ReadData2, 32'h55);
    chk("ld_wb_busy_still", BusyMask, 32'h0000_0010);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("ld_cleared", BusyMask, 32'h0);
    chk("ld_cleared_stall", {31'b0, LoadStall}, 32'h0);
    chk("ld_stored_rd2", ReadData2, 32'h55);

    // Same-cycle clear and set on r4: set wins.
    ReadReg2 = 5'd0;
    wb(1'b1, 5'd4, 32'h66);
    LoadIssue = 1'b1; LoadDst = 5'd4;
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    LoadIssue = 1'b0; LoadDst = 5'd0;
    ReadReg1 = 5'd4;
    #1;
    chk("setclr_busy", BusyMask, 32'h0000_0010);
    chk("setclr_stall", {31'b0, LoadStall}, 32'h1);
    chk("setclr_data", ReadData1, 32'h66);

    // Load to r0 has no effect.
    ReadReg1 = 5'd0;
    LoadIssue = 1'b1; LoadDst = 5'd0;
    next_cycle();
    LoadIssue = 1'b0;
    #1;
    chk("ld_r0_busy", BusyMask, 32'h0000_0010);
    chk("ld_r0_stall", {31'b0, LoadStall}, 32'h0);

    // Reset mid-flight: r3 = 0x77 stored, pending loads on r3 and r8 (r4 still pending).
    wb(1'b1, 5'd3, 32'h77);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    LoadIssue = 1'b1; LoadDst = 5'd3;
    next_cycle();
    LoadDst = 5'd8;
    next_cycle();
    LoadIssue = 1'b0; LoadDst = 5'd0;
    ReadReg1 = 5'd3;
    #1;
    chk("pre_rst_busy", BusyMask, 32'h0000_0118);
    chk("pre_rst_stall", {31'b0, LoadStall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", BusyMask, 32'h0);
    chk("mid_rst_rd1", ReadData1, 32'h0);
    chk("mid_rst_stall", {31'b0, LoadStall}, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_rd1", ReadData1, 32'h0);
    chk("post_rst_busy", BusyMask, 32'h0);
    ReadReg2 = 5'd7;
    #1;
    chk("post_rst_r7", ReadData2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
